branch_predictor_bht: RTL and testbench

//  Per-PC branch history table (BHT) of saturating counters replacing the single global 2-bit FSM.

---
 rtl/bp_pkg.sv | 19 +
 rtl/bp_counter_table.sv | 26 ++
 rtl/branch_predictor_bht.sv | 55 +++++
 tb/tb_branch_predictor_bht.sv | 104 ++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// bp_pkg: shared counter encodings, saturating counter helpers and PC index extraction for the BHT predictor
package bp_pkg;
  localparam int CTR_MAX = 8;
  localparam int IDX_MAX = 16;
  typedef enum logic [1:0] {BP_SNT = 2'b00, BP_WNT = 2'b01, BP_WT = 2'b10, BP_ST = 2'b11} bp_state_e;
  function automatic logic [CTR_MAX-1:0] sat_inc(input logic [CTR_MAX-1:0] c, input int bits);
    logic [CTR_MAX-1:0] mx;
    mx = {CTR_MAX{1'b1}} >> (CTR_MAX - bits);
    return c == mx ? c : c + 1'b1;
  endfunction
  function automatic logic [CTR_MAX-1:0] sat_dec(input logic [CTR_MAX-1:0] c);
    return c == '0 ? c : c - 1'b1;
  endfunction
  function automatic logic [IDX_MAX-1:0] pc_index(input logic [63:0] pc, input int bits);
    logic [63:0] s;
    s = pc >> 2;
    return IDX_MAX'(s) & ((IDX_MAX'(1) << bits) - IDX_MAX'(1));
  endfunction
endpackage

// File: rtl/bp_counter_table.sv
// bp_counter_table: 2^INDEX_BITS saturating counters, one combinational read port and one synchronous update port
module bp_counter_table
  import bp_pkg::*;
#(
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int CTR_INIT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_BITS-1:0]   rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_taken
);
  logic [CTR_BITS-1:0] tbl [2**INDEX_BITS];
  assign rd_ctr = tbl[rd_idx];
  // reset every counter to its initial bias; otherwise train only the addressed entry
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int i = 0; i < 2**INDEX_BITS; i++) tbl[i] <= CTR_BITS'(CTR_INIT);
    else if (wr_en)
      tbl[wr_idx] <= wr_taken ? CTR_BITS'(sat_inc(CTR_MAX'(tbl[wr_idx]), CTR_BITS))
                              : CTR_BITS'(sat_dec(CTR_MAX'(tbl[wr_idx])));
endmodule

// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht: per-PC BHT predictor with registered target adder; define BP_GSHARE_EN for gshare history hashing
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int INDEX_BITS = 6,
  parameter int CTR_BITS   = 2,
  parameter int CTR_INIT   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lookup_valid,
  input  logic [ADDR_W-1:0] lookup_pc,
  input  logic [ADDR_W-1:0] lookup_offset,
  output logic              prediction,
  output logic [ADDR_W-1:0] branch_addr,
  input  logic              update_valid,
  input  logic [ADDR_W-1:0] update_pc,
  input  logic              update_taken
);
  logic [INDEX_BITS-1:0] lookup_pc_idx, update_pc_idx, lookup_idx, update_idx;
  logic [CTR_BITS-1:0] rd_ctr;
  assign lookup_pc_idx = INDEX_BITS'(pc_index(64'(lookup_pc), INDEX_BITS));
  assign update_pc_idx = INDEX_BITS'(pc_index(64'(update_pc), INDEX_BITS));
`ifdef BP_GSHARE_EN
  logic [INDEX_BITS-1:0] ghr;
  // shift each committed outcome into the global history
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ghr <= '0;
    else if (update_valid) ghr <= {ghr[INDEX_BITS-2:0], update_taken};
  assign lookup_idx = lookup_pc_idx ^ ghr;
  assign update_idx = update_pc_idx ^ ghr;
`else
  assign lookup_idx = lookup_pc_idx;
  assign update_idx = update_pc_idx;
`endif
  // branch target registered one cycle after decode, carry out dropped
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) branch_addr <= '0;
    else branch_addr <= lookup_pc + lookup_offset;
  assign prediction = rst_n & lookup_valid & rd_ctr[CTR_BITS-1];
  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS),
    .CTR_BITS  (CTR_BITS),
    .CTR_INIT  (CTR_INIT)
  ) u_table (
    .clk     (clk),
    .rst_n   (rst_n),
    .rd_idx  (lookup_idx),
    .rd_ctr  (rd_ctr),
    .wr_en   (update_valid),
    .wr_idx  (update_idx),
    .wr_taken(update_taken)
  );
endmodule

// File: tb/tb_branch_predictor_bht.sv
// tb_branch_predictor_bht: scoreboard bench checking predictions, training, aliasing, collisions and target wrap
module tb_branch_predictor_bht;
  logic clk = 0, rst_n = 1, lookup_valid = 0, update_valid = 0, update_taken = 0;
  logic [31:0] lookup_pc = 0, lookup_offset = 0, update_pc = 0;
  logic prediction;
  logic [31:0] branch_addr;
  int errs = 0, checks = 0;
  int mdl [64];
  int ghr = 0;
  logic pred_q [$];
  logic [31:0] addr_q [$];

  branch_predictor_bht dut (
    .clk(clk), .rst_n(rst_n), .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .lookup_offset(lookup_offset), .prediction(prediction), .branch_addr(branch_addr),
    .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) & 32'd63) ^ ghr;
  endfunction

  task automatic step(input string tag, input logic lv, input logic [31:0] lpc, input logic [31:0] loff,
                      input logic uv, input logic [31:0] upc, input logic ut);
    lookup_valid = lv; lookup_pc = lpc; lookup_offset = loff;
    update_valid = uv; update_pc = upc; update_taken = ut;
    pred_q.push_back(lv && mdl[idx(lpc)] >= 2);
    addr_q.push_back(lpc + loff);
    #1 check({tag, "_pred"}, 32'(prediction), 32'(pred_q.pop_front()));
    @(posedge clk);
    if (uv) begin
      int i;
      i = idx(upc);
      mdl[i] = ut ? (mdl[i] == 3 ? 3 : mdl[i] + 1) : (mdl[i] == 0 ? 0 : mdl[i] - 1);
`ifdef BP_GSHARE_EN
      ghr = ((ghr << 1) | int'(ut)) & 63;
`endif
    end
    #1 check({tag, "_addr"}, branch_addr, addr_q.pop_front());
    @(negedge clk);
  endtask

  task automatic do_reset();
    lookup_valid = 1; lookup_pc = 32'h40; lookup_offset = 32'h10;
    update_valid = 0;
    #2 rst_n = 0;
    #1 check("rst_pred", 32'(prediction), 32'd0);
    check("rst_addr", branch_addr, 32'd0);
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    ghr = 0;
    @(negedge clk);
    check("rst_hold_addr", branch_addr, 32'd0);
    rst_n = 1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 1;
    @(negedge clk);
    do_reset();
    for (int k = 0; k < 4; k++) step("sat_up", 1, 32'h40, 32'h0, 1, 32'h40, 1);
    step("sat_top", 1, 32'h40, 32'h4, 0, 0, 0);
    for (int k = 0; k < 4; k++) step("sat_dn", 1, 32'h40, 32'h8, 1, 32'h40, 0);
    step("sat_bot", 1, 32'h40, 32'hc, 1, 32'h40, 1);
    step("sat_bot2", 1, 32'h40, 32'hc, 0, 0, 0);
    step("iso_tr", 0, 32'h0, 32'h0, 1, 32'h40, 1);
    step("iso_44", 1, 32'h44, 32'h0, 0, 0, 0);
    step("alias_140", 1, 32'h140, 32'h0, 0, 0, 0);
    step("iso_40", 1, 32'h40, 32'h0, 1, 32'h40, 0);
    step("col_same", 1, 32'h40, 32'h0, 1, 32'h40, 1);
    step("col_next", 1, 32'h40, 32'h0, 0, 0, 0);
    step("col_diff", 1, 32'h80, 32'h0, 1, 32'h40, 1);
    step("tgt_neg", 1, 32'h100, 32'hFFFFFFF8, 0, 0, 0);
    step("tgt_wrap", 1, 32'hFFFFFFFC, 32'h8, 0, 0, 0);
    step("tgt_noval", 0, 32'h1234, 32'h10, 0, 0, 0);
    for (int k = 0; k < 60; k++)
      step("rnd", 1'($urandom), 32'($urandom_range(0, 15)) << 4, $urandom, 1'($urandom),
           32'($urandom_range(0, 15)) << 4, 1'($urandom));
    step("pre_rst", 1, 32'h40, 32'h0, 1, 32'h40, 1);
    step("pre_rst2", 1, 32'h40, 32'h0, 1, 32'h40, 1);
    do_reset();
    step("post_rst", 1, 32'h40, 32'h0, 1, 32'h40, 1);
    step("post_rst_wt", 1, 32'h40, 32'h0, 0, 0, 0);
    step("post_rst_other", 1, 32'h80, 32'h0, 0, 0, 0);
`ifdef BP_GSHARE_EN
    do_reset();
    step("gs_t0", 0, 32'h0, 32'h0, 1, 32'h4C, 1);
    step("gs_t1", 0, 32'h0, 32'h0, 1, 32'h0, 1);
    check("gs_ghr_model", 32'(ghr), 32'h3);
    step("gs_lookup", 1, 32'h40, 32'h0, 0, 0, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
